bsg_downstream_read_sequencer: RTL
==================================

// Module: bsg_downstream_read_sequencer
// PURPOSE
//  Read-side controller for the downstream channel buffer (64 x 16-bit).
//  Fetches two consecutive half-word entries, packs them into one 32-bit core
//  word, presents it with a valid/ready handshake and returns credit tokens to
//  the IO side.
//  Sits between the buffer read port and the core; wptr arrives already synced.
// PARAMETERS
//  ADDR_W       6   buffer address width; DEPTH = 2**ADDR_W entries
//  TOKEN_RATIO  4   entries consumed per io_token_out pulse (power of 2, >=2)
// PORTS
//  clk            in   1         clock
//  rst            in   1         synchronous, active-high reset
//  wptr_sync      in   ADDR_W+1  write pointer, binary, synced to clk
//  buf_addr       out  ADDR_W    buffer read address (= rptr[ADDR_W-1:0])
//  buf_rd_en      out  1         read strobe; buf_data valid on the next cycle
//  buf_data       in   16        buffer read data (1-cycle latency)
//  core_valid_out out  1         packed word valid
//  core_data_out  out  32        {second entry, first entry}
//  core_ready     in   1         core accepts word when valid & ready
//  io_token_out   out  1         1-cycle credit pulse to IO side
//  rptr           out  ADDR_W+1  read pointer, binary, wraps mod 2**(ADDR_W+1)
//  empty          out  1         wptr_sync == rptr
//  overflow_err   out  1         sticky: occupancy > DEPTH seen
// BEHAVIOUR
//  Reset (sync, rst=1): state=IDLE, rptr=0, core_valid_out=0,
//   core_data_out=0, io_token_out=0, buf_rd_en=0, token count=0,
//   overflow_err=0. Mid-operation reset aborts any pending word, no token.
//  occupancy = (wptr_sync - rptr) mod 2**(ADDR_W+1); empty = (occupancy==0).
//  Issue a read (ISSUE): buf_rd_en=1, buf_addr=rptr[ADDR_W-1:0], rptr<=rptr+1.
//  FSM:
//   IDLE:     if !empty: ISSUE -> CAP_LO; else stay.
//   CAP_LO:   data_lo<=buf_data; if occupancy>0 after the increment: ISSUE ->
//             CAP_HI; else -> FETCH_HI.
//   FETCH_HI: if !empty: ISSUE -> CAP_HI; else stay (lo held).
//   CAP_HI:   core_data_out<={buf_data,data_lo}; core_valid_out<=1 -> OUT.
//   OUT:      hold core_valid_out/core_data_out stable until core_ready.
//             On core_ready: valid<=0; if !empty: ISSUE -> CAP_LO (back-to-back);
//             else -> IDLE.
//  Min latency: first entry visible to word on core_valid_out = 3 cycles
//   (IDLE issue, CAP_LO issue, CAP_HI).
//  Steady throughput: 1 word per 3 cycles with core_ready=1.
//  Token: count increments on every ISSUE. When the count reaches TOKEN_RATIO,
//   io_token_out=1 for the next cycle and the count resets to 0.
//   Tokens never coalesce; at most one pulse per TOKEN_RATIO reads.
//  Wrap: rptr wraps 127->0 (ADDR_W=6); buf_addr wraps 63->0 silently.
//  overflow_err set when occupancy > DEPTH; cleared only by rst; no other effect.
//  core_ready while !core_valid_out is ignored.
//  wptr_sync moving during FETCH_HI is sampled each cycle.
// TESTING
//  1 rst, wptr_sync=2, buf[0]=16'hAAAA, buf[1]=16'h5555, core_ready=1 ->
//    core_data_out=32'h5555AAAA valid in cycle 3; rptr=2; empty=1; no token.
//  2 wptr_sync=8, core_ready=1 -> 4 words back-to-back, 1 per 3 cycles;
//    io_token_out pulses twice, after reads 4 and 8; rptr=8.
//  3 wptr_sync=1, hold 10 cycles, then 2 -> FSM waits in FETCH_HI, lo intact;
//    word = {buf[1],buf[0]}.
//  4 core_ready=0 for 5 cycles in OUT -> valid and data stable; no new reads
//    issued; accept on cycle 6.
//  5 rptr preset to 126 via 126 prior reads, wptr_sync=0 (2 entries) ->
//    reads buf_addr 62,63; rptr wraps to 0; word correct.
//  6 rst asserted in CAP_HI -> next cycle all outputs at reset values;
//    wptr_sync=66 with rptr=0 -> overflow_err=1 and stays set.

Source files
------------

// File: rtl/bsg_downstream_read_sequencer.sv
// Read-side sequencer for the downstream channel buffer: fetches two 16-bit
// entries, packs them into one 32-bit core word and returns IO credit tokens.
module bsg_downstream_read_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int TOKEN_RATIO = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   wptr_sync,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_rd_en,
    input  logic [15:0]       buf_data,
    output logic              core_valid_out,
    output logic [31:0]       core_data_out,
    input  logic              core_ready,
    output logic              io_token_out,
    output logic [ADDR_W:0]   rptr,
    output logic              empty,
    output logic              overflow_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(TOKEN_RATIO);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAP_LO   = 3'd1,
        FETCH_HI = 3'd2,
        CAP_HI   = 3'd3,
        OUT      = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               issue;
    logic               word_load;
    logic [ADDR_W:0]    occupancy;
    logic [15:0]        data_lo;
    logic [CNT_W-1:0]   tok_cnt;

    // Pointers are one bit wider than the address so full and empty differ.
    assign occupancy = wptr_sync - rptr;
    assign empty     = (occupancy == '0);
    assign buf_addr  = rptr[ADDR_W-1:0];
    assign buf_rd_en = issue & ~rst;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        word_load = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    issue     = 1'b1;
                    state_nxt = CAP_LO;
                end
            end
            CAP_LO: begin
                if (!empty) begin
                    issue     = 1'b1;
                    state_nxt = CAP_HI;
                end else begin
                    state_nxt = FETCH_HI;
                end
            end
            FETCH_HI: begin
                if (!empty) begin
                    issue     = 1'b1;
                    state_nxt = CAP_HI;
                end
            end
            CAP_HI: begin
                word_load = 1'b1;
                state_nxt = OUT;
            end
            OUT: begin
                if (core_ready) begin
                    if (!empty) begin
                        issue     = 1'b1;
                        state_nxt = CAP_LO;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rptr           <= '0;
            data_lo        <= '0;
            core_valid_out <= 1'b0;
            core_data_out  <= '0;
            io_token_out   <= 1'b0;
            tok_cnt        <= '0;
            overflow_err   <= 1'b0;
        end else begin
            state        <= state_nxt;
            io_token_out <= 1'b0;
            if (issue) begin
                rptr <= rptr + (ADDR_W+1)'(1);
                if (tok_cnt == CNT_W'(TOKEN_RATIO - 1)) begin
                    tok_cnt      <= '0;
                    io_token_out <= 1'b1;
                end else begin
                    tok_cnt <= tok_cnt + CNT_W'(1);
                end
            end
            if (state == CAP_LO) begin
                data_lo <= buf_data;
            end
            if (word_load) begin
                core_data_out  <= {buf_data, data_lo};
                core_valid_out <= 1'b1;
            end else if (state == OUT && core_ready) begin
                core_valid_out <= 1'b0;
            end
            if (occupancy > (ADDR_W+1)'(DEPTH)) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule
